// File: rtl/wr_arria10_rx_align_ctrl.sv
// RX word-alignment controller for the Arria10 deterministic-latency PHY (rx_clkout domain).
// Optional 8b10b error monitor in LOCKED is built when WR_RX_ALIGN_ERRMON_EN is defined.
//
// state      | meaning
// IDLE       | disabled, control outputs low
// WAIT_LOCK  | waiting for CDR lock to data
// SETTLE     | lock held for g_settle_cycles before aligning
// ALIGN      | pattern-align request to the PHY, 4 cycles
// WAIT_SYNC  | waiting for word-aligner sync, bounded by g_sync_timeout
// CHECK      | sample slip boundary, accept only even values
// RESET_RX   | RX digital-reset pulse of g_reset_cycles, then retry
// LOCKED     | aligned with an even boundary, bitslide published
module wr_arria10_rx_align_ctrl #(
  parameter int g_settle_cycles = 1024,
  parameter int g_sync_timeout  = 65536,
  parameter int g_reset_cycles  = 64,
  parameter int g_max_retries   = 15,
  parameter int g_err_window    = 4096,
  parameter int g_err_threshold = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       rx_lockedtodata_i,
  input  logic       rx_syncstatus_i,
  input  logic [4:0] rx_bitslipboundarysel_i,
  input  logic       rx_errdetect_i,
  input  logic       rx_disperr_i,
  output logic       rx_patternalign_o,
  output logic       rx_digitalreset_o,
  output logic [4:0] rx_bitslide_o,
  output logic       rx_aligned_o,
  output logic [3:0] retry_cnt_o,
  output logic       align_fail_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_SETTLE, S_ALIGN, S_WAIT_SYNC, S_CHECK, S_RESET_RX, S_LOCKED
  } state_t;

  // One shared down-counter serves every timed state, so size it for the longest.
  localparam int c_max_a = (g_settle_cycles > g_sync_timeout) ? g_settle_cycles : g_sync_timeout;
  localparam int c_max_b = (g_reset_cycles > 4) ? g_reset_cycles : 4;
  localparam int c_max   = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_tw    = $clog2(c_max);

  state_t          state;
  logic [c_tw-1:0] timer;
  logic            enable_q;
  logic [3:0]      retry_inc;
  logic            retry_req;
  logic            err_trip;

`ifdef WR_RX_ALIGN_ERRMON_EN
  localparam int c_ww = $clog2(g_err_window);
  localparam int c_ew = $clog2(g_err_threshold + 1);

  logic [c_ww-1:0] win_cnt;
  logic [c_ew-1:0] err_cnt;
  logic            err_hit;

  assign err_hit  = rx_errdetect_i | rx_disperr_i;
  assign err_trip = (int'(err_cnt) + int'(err_hit)) >= g_err_threshold;

  // Window and count stay cleared outside LOCKED, so each LOCKED entry starts fresh.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (state != S_LOCKED) begin
      win_cnt <= c_ww'(g_err_window - 1);
      err_cnt <= '0;
    end else if (win_cnt == '0) begin
      win_cnt <= c_ww'(g_err_window - 1);
      err_cnt <= '0;
    end else begin
      win_cnt <= win_cnt - c_ww'(1);
      if (err_hit && (err_cnt != '1))
        err_cnt <= err_cnt + c_ew'(1);
    end
  end
`else
  localparam int c_unused_errmon = g_err_window + g_err_threshold;
  logic unused_err;
  assign unused_err = rx_errdetect_i ^ rx_disperr_i;
  assign err_trip   = 1'b0;
`endif

  assign retry_inc = (retry_cnt_o == 4'hf) ? 4'hf : retry_cnt_o + 4'd1;

  // Loss of lock in WAIT_SYNC takes priority over the timeout and does not count as a retry.
  assign retry_req =
      ((state == S_WAIT_SYNC) && rx_lockedtodata_i && !rx_syncstatus_i && (timer == '0)) ||
      ((state == S_CHECK) && rx_bitslipboundarysel_i[0]) ||
      ((state == S_LOCKED) && rx_lockedtodata_i && rx_syncstatus_i && err_trip);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= S_IDLE;
      timer             <= '0;
      enable_q          <= 1'b0;
      rx_patternalign_o <= 1'b0;
      rx_digitalreset_o <= 1'b0;
      rx_bitslide_o     <= '0;
      rx_aligned_o      <= 1'b0;
      retry_cnt_o       <= '0;
      align_fail_o      <= 1'b0;
    end else begin
      enable_q          <= enable_i;
      rx_patternalign_o <= 1'b0;
      rx_digitalreset_o <= 1'b0;
      rx_aligned_o      <= 1'b0;
      if (!enable_i) begin
        state <= S_IDLE;
        timer <= '0;
      end else begin
        rx_patternalign_o <= (state == S_ALIGN);
        rx_digitalreset_o <= (state == S_RESET_RX);
        if (!enable_q) begin
          retry_cnt_o  <= '0;
          align_fail_o <= 1'b0;
        end else if (retry_req) begin
          retry_cnt_o <= retry_inc;
          if (int'(retry_inc) >= g_max_retries)
            align_fail_o <= 1'b1;
        end
        case (state)
          S_IDLE: state <= S_WAIT_LOCK;
          S_WAIT_LOCK: begin
            if (rx_lockedtodata_i) begin
              state <= S_SETTLE;
              timer <= c_tw'(g_settle_cycles - 1);
            end
          end
          S_SETTLE: begin
            if (!rx_lockedtodata_i) begin
              state <= S_WAIT_LOCK;
            end else if (timer == '0) begin
              state <= S_ALIGN;
              timer <= c_tw'(3);
            end else begin
              timer <= timer - c_tw'(1);
            end
          end
          S_ALIGN: begin
            if (timer == '0) begin
              state <= S_WAIT_SYNC;
              timer <= c_tw'(g_sync_timeout - 1);
            end else begin
              timer <= timer - c_tw'(1);
            end
          end
          S_WAIT_SYNC: begin
            if (!rx_lockedtodata_i) begin
              state <= S_WAIT_LOCK;
            end else if (rx_syncstatus_i) begin
              state <= S_CHECK;
            end else if (timer == '0) begin
              state <= S_RESET_RX;
              timer <= c_tw'(g_reset_cycles - 1);
            end else begin
              timer <= timer - c_tw'(1);
            end
          end
          S_CHECK: begin
            if (rx_bitslipboundarysel_i[0]) begin
              state <= S_RESET_RX;
              timer <= c_tw'(g_reset_cycles - 1);
            end else begin
              rx_bitslide_o <= rx_bitslipboundarysel_i;
              state         <= S_LOCKED;
            end
          end
          S_RESET_RX: begin
            if (timer == '0)
              state <= S_WAIT_LOCK;
            else
              timer <= timer - c_tw'(1);
          end
          S_LOCKED: begin
            if (!rx_syncstatus_i || !rx_lockedtodata_i) begin
              state <= S_WAIT_LOCK;
            end else if (err_trip) begin
              state <= S_RESET_RX;
              timer <= c_tw'(g_reset_cycles - 1);
            end else begin
              rx_aligned_o <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
